// File: rtl/npu_fifo_burst_arbiter.sv
// Burst round-robin write arbiter and threshold/flush drain scheduler for the NPU circular-buffer FIFO.
// Optional build macro NPU_ARB_HIPRI_EN gives requester 0 strict priority over the round-robin pointer.
module npu_fifo_burst_arbiter #(
    parameter int NREQ         = 4,
    parameter int DW           = 16,
    parameter int DEPTH        = 32,
    parameter int BURST_LEN    = 4,
    parameter int DRAIN_THRESH = 8,
    parameter int DRAIN_LEN    = 8,
    parameter int LW           = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      fifo_din,
    output logic               fifo_wr_en,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic               cons_ready,
    input  logic               flush,
    output logic               rd_valid,
    output logic [LW-1:0]      level,
    output logic               wr_busy,
    output logic               rd_busy
);

    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW  = $clog2(BURST_LEN + 1);
    localparam int DCW = $clog2(DRAIN_LEN + 1);

    typedef enum logic {W_IDLE, W_BURST} wstate_e;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

    wstate_e         wst_q, wst_d;
    rstate_e         rdst_q, rdst_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [OW-1:0]   pick, rr_next;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [LW-1:0]   level_q, level_d;
    logic            rd_valid_q;
    logic [DW-1:0]   din_q, din_d;
    logic [DW-1:0]   owner_data;
    logic            owner_req;
    logic            wr_fire, rd_fire;
    logic            flush_mode;
    logic            hipri_preempt;

    // First requester at or above the rr pointer, wrapping.
    always_comb begin
        logic [OW:0] sum;
        logic        found;
        pick  = rr_q;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_q} + (OW+1)'(i);
            if (sum >= (OW+1)'(NREQ))
                sum = sum - (OW+1)'(NREQ);
            if (!found && req[sum[OW-1:0]]) begin
                pick  = sum[OW-1:0];
                found = 1'b1;
            end
        end
`ifdef NPU_ARB_HIPRI_EN
        if (req[0])
            pick = '0;
`endif
    end

    always_comb begin
        owner_data = '0;
        owner_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_data = req_data[i*DW +: DW];
                owner_req  = req[i];
            end
        end
    end

    assign rr_next = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;

`ifdef NPU_ARB_HIPRI_EN
    assign hipri_preempt = req[0] && (owner_q != '0);
`else
    assign hipri_preempt = 1'b0;
`endif

    // Grant and read strobe are combinational; rst masks them so a reset cycle never writes or reads.
    always_comb begin
        gnt = '0;
        if (wst_q == W_BURST && owner_req && !fifo_full && !rst)
            gnt[owner_q] = 1'b1;
    end

    assign wr_fire    = |gnt;
    assign rd_fire    = (rdst_q == R_DRAIN) && cons_ready && !fifo_empty && !rst;
    assign flush_mode = flush_pend_q | flush;
    assign din_d      = wr_fire ? owner_data : din_q;

    always_comb begin
        wst_d   = wst_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        bcnt_d  = bcnt_q;
        case (wst_q)
            W_IDLE: begin
                if (|req) begin
                    owner_d = pick;
                    bcnt_d  = '0;
                    wst_d   = W_BURST;
                end
            end
            W_BURST: begin
                if (wr_fire)
                    bcnt_d = bcnt_q + 1'b1;
                if (!owner_req || hipri_preempt ||
                    (wr_fire && bcnt_q == BW'(BURST_LEN-1))) begin
                    wst_d = W_IDLE;
`ifdef NPU_ARB_HIPRI_EN
                    if (owner_q != '0)
                        rr_d = rr_next;
`else
                    rr_d = rr_next;
`endif
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        rdst_d       = rdst_q;
        dcnt_d       = dcnt_q;
        flush_pend_d = flush_pend_q;
        case (rdst_q)
            R_IDLE: begin
                if (level_q >= LW'(DRAIN_THRESH) || flush_pend_q) begin
                    rdst_d = R_DRAIN;
                    dcnt_d = '0;
                end
            end
            R_DRAIN: begin
                if (rd_fire)
                    dcnt_d = dcnt_q + 1'b1;
                if (fifo_empty && !rd_fire) begin
                    rdst_d       = R_IDLE;
                    flush_pend_d = 1'b0;
                end else if (rd_fire && !flush_mode && dcnt_q == DCW'(DRAIN_LEN-1)) begin
                    rdst_d = R_IDLE;
                end
            end
            default: rdst_d = R_IDLE;
        endcase
        if (flush)
            flush_pend_d = 1'b1;
    end

    // Saturating occupancy; a simultaneous write and read leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (wr_fire && !rd_fire && level_q != LW'(DEPTH))
            level_d = level_q + 1'b1;
        else if (rd_fire && !wr_fire && level_q != '0)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wst_q        <= W_IDLE;
            rdst_q       <= R_IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            bcnt_q       <= '0;
            dcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            level_q      <= '0;
            rd_valid_q   <= 1'b0;
            din_q        <= '0;
        end else begin
            wst_q        <= wst_d;
            rdst_q       <= rdst_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            bcnt_q       <= bcnt_d;
            dcnt_q       <= dcnt_d;
            flush_pend_q <= flush_pend_d;
            level_q      <= level_d;
            rd_valid_q   <= rd_fire;
            din_q        <= din_d;
        end
    end

    assign fifo_din   = din_d;
    assign fifo_wr_en = wr_fire;
    assign fifo_rd_en = rd_fire;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign wr_busy    = (wst_q == W_BURST);
    assign rd_busy    = (rdst_q == R_DRAIN);

endmodule

// File: tb/tb_npu_fifo_burst_arbiter.sv
// Directed bench for npu_fifo_burst_arbiter with a behavioural 32-deep FIFO attached.
module tb_npu_fifo_burst_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int LW    = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      fifo_din;
    logic               fifo_wr_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic               cons_ready = 1'b0;
    logic               flush = 1'b0;
    logic               rd_valid;
    logic [LW-1:0]      level;
    logic               wr_busy;
    logic               rd_busy;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    npu_fifo_burst_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .cons_ready(cons_ready),
        .flush(flush), .rd_valid(rd_valid), .level(level), .wr_busy(wr_busy),
        .rd_busy(rd_busy)
    );

    // Behavioural circular-buffer FIFO with registered dout.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout;
    int wp, rp, cnt;
    assign fifo_full  = (cnt == DEPTH);
    assign fifo_empty = (cnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            wp <= 0; rp <= 0; cnt <= 0; dout <= '0;
        end else begin
            int d;
            d = 0;
            if (fifo_wr_en && cnt < DEPTH) begin
                mem[wp] <= fifo_din; wp <= (wp + 1) % DEPTH; d = d + 1;
            end
            if (fifo_rd_en && cnt > 0) begin
                dout <= mem[rp]; rp <= (rp + 1) % DEPTH; d = d - 1;
            end
            cnt <= cnt + d;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_data = '0; cons_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (gnt !== '0) begin errs++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        checks++; if (fifo_wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        checks++; if (fifo_din !== '0) begin errs++; $display("FAIL reset_din: got %h want 0", fifo_din); end
        checks++; if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        checks++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (level !== '0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (wr_busy !== 1'b0) begin errs++; $display("FAIL reset_wr_busy: got %b want 0", wr_busy); end
        checks++; if (rd_busy !== 1'b0) begin errs++; $display("FAIL reset_rd_busy: got %b want 0", rd_busy); end
    endtask

    // req[2] alone: two 4-word bursts separated by one arbitration cycle.
    task automatic test_single_req();
        int n;
        logic [NREQ-1:0] exp;
        n = 0;
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            set_data(2, 16'h0100 + 16'(n));
            #1;
            exp = (c == 0 || c == 5) ? 4'b0000 : 4'b0100;
            checks++;
            if (gnt !== exp) begin errs++; $display("FAIL single_gnt c=%0d: got %b want %b", c, gnt, exp); end
            if (gnt[2]) n++;
            tick();
        end
        req = '0;
        #1;
        checks++; if (level !== LW'(8)) begin errs++; $display("FAIL single_level: got %0d want 8", level); end
        tick();
        checks++; if (rd_busy !== 1'b1) begin errs++; $display("FAIL single_rd_busy: got %b want 1", rd_busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL single_rd_en_noready: got %b want 0", fifo_rd_en); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem[k] !== 16'h0100 + 16'(k)) begin
                errs++; $display("FAIL single_data[%0d]: got %h want %h", k, mem[k], 16'h0100 + 16'(k));
            end
        end
    endtask

    task automatic test_thresh_drain();
        logic prev_rd;
        logic [DW-1:0] rq[$];
        prev_rd = 1'b0;
        cons_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            #1;
            checks++;
            if (fifo_rd_en !== (j < 8)) begin errs++; $display("FAIL drain_rd_en j=%0d: got %b want %b", j, fifo_rd_en, (j < 8)); end
            checks++;
            if (rd_valid !== prev_rd) begin errs++; $display("FAIL drain_rd_valid j=%0d: got %b want %b", j, rd_valid, prev_rd); end
            if (rd_valid) rq.push_back(dout);
            prev_rd = fifo_rd_en;
            tick();
        end
        checks++; if (level !== '0) begin errs++; $display("FAIL drain_level: got %0d want 0", level); end
        checks++; if (rd_busy !== 1'b0) begin errs++; $display("FAIL drain_rd_busy: got %b want 0", rd_busy); end
        checks++;
        if (rq.size() != 8) begin errs++; $display("FAIL drain_count: got %0d want 8", rq.size()); end
        else begin
            for (int k = 0; k < 8; k++)
                if (rq[k] !== 16'h0100 + 16'(k)) begin
                    errs++; $display("FAIL drain_data[%0d]: got %h want %h", k, rq[k], 16'h0100 + 16'(k));
                end
        end
        cons_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp;
        logic [DW-1:0] exp_din;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 16'hA000 + 16'(i));
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (c % 5 == 0) begin
                exp = '0;
                exp_din = (c == 0) ? 16'h0000 : 16'hA000 + 16'(((c / 5) - 1) % 4);
            end else begin
                exp = 4'b0001 << ((c / 5) % 4);
                exp_din = 16'hA000 + 16'((c / 5) % 4);
            end
            checks++;
            if (gnt !== exp) begin errs++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt, exp); end
            checks++;
            if (!$onehot0(gnt)) begin errs++; $display("FAIL rr_onehot c=%0d: got %b want at most one bit", c, gnt); end
            checks++;
            if (fifo_din !== exp_din) begin errs++; $display("FAIL rr_din c=%0d: got %h want %h", c, fifo_din, exp_din); end
            tick();
        end
        req = '0;
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        set_data(1, 16'hB000);
        req = 4'b0010;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (c >= 41) begin
                checks++; if (fifo_full !== 1'b1) begin errs++; $display("FAIL full_flag c=%0d: got %b want 1", c, fifo_full); end
                checks++; if (gnt !== '0) begin errs++; $display("FAIL full_gnt c=%0d: got %b want 0", c, gnt); end
                checks++; if (fifo_wr_en !== 1'b0) begin errs++; $display("FAIL full_wr_en c=%0d: got %b want 0", c, fifo_wr_en); end
                checks++; if (wr_busy !== 1'b1) begin errs++; $display("FAIL full_wr_busy c=%0d: got %b want 1", c, wr_busy); end
                checks++; if (level !== LW'(32)) begin errs++; $display("FAIL full_level c=%0d: got %0d want 32", c, level); end
            end
            tick();
        end
        cons_ready = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errs++; $display("FAIL full_resume_rd: got %b want 1", fifo_rd_en); end
        checks++; if (gnt !== '0) begin errs++; $display("FAIL full_resume_gnt0: got %b want 0", gnt); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errs++; $display("FAIL full_resume_gnt1: got %b want 0010", gnt); end
        checks++; if (fifo_rd_en !== 1'b1) begin errs++; $display("FAIL full_resume_rd2: got %b want 1", fifo_rd_en); end
        tick();
        checks++; if (level !== LW'(31)) begin errs++; $display("FAIL full_resume_level: got %0d want 31", level); end
        req = '0; cons_ready = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int n;
        logic [DW-1:0] rq[$];
        do_reset();
        cons_ready = 1'b1;
        n = 0;
        req = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            set_data(3, 16'hC000 + 16'(n));
            #1;
            if (gnt[3]) n++;
            tick();
        end
        req = '0;
        tick(); tick();
        checks++; if (level !== LW'(3)) begin errs++; $display("FAIL flush_prelevel: got %0d want 3", level); end
        checks++; if (rd_busy !== 1'b0) begin errs++; $display("FAIL flush_nodrain: got %b want 0", rd_busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int j = 0; j < 8; j++) begin
            #1;
            checks++;
            if (fifo_rd_en !== (j >= 1 && j <= 3)) begin
                errs++; $display("FAIL flush_rd_en j=%0d: got %b want %b", j, fifo_rd_en, (j >= 1 && j <= 3));
            end
            checks++;
            if (rd_busy !== (j >= 1 && j <= 4)) begin
                errs++; $display("FAIL flush_rd_busy j=%0d: got %b want %b", j, rd_busy, (j >= 1 && j <= 4));
            end
            if (rd_valid) rq.push_back(dout);
            tick();
        end
        checks++; if (level !== '0) begin errs++; $display("FAIL flush_level: got %0d want 0", level); end
        checks++;
        if (rq.size() != 3) begin errs++; $display("FAIL flush_count: got %0d want 3", rq.size()); end
        else begin
            for (int k = 0; k < 3; k++)
                if (rq[k] !== 16'hC000 + 16'(k)) begin
                    errs++; $display("FAIL flush_data[%0d]: got %h want %h", k, rq[k], 16'hC000 + 16'(k));
                end
        end
        cons_ready = 1'b0;
    endtask

    // Owner 2 completes a burst (rr -> 3), owner 3 is reset after 2 words; rr must restart at 0.
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 16'hD000 + 16'(i));
        req = 4'b1100;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 6) begin
                checks++; if (gnt !== 4'b1000) begin errs++; $display("FAIL rstmid_owner3: got %b want 1000", gnt); end
            end
            tick();
        end
        rst = 1'b1;
        #1;
        checks++; if (gnt !== '0) begin errs++; $display("FAIL rstmid_gnt_in_rst: got %b want 0", gnt); end
        checks++; if (fifo_wr_en !== 1'b0) begin errs++; $display("FAIL rstmid_wr_in_rst: got %b want 0", fifo_wr_en); end
        tick();
        rst = 1'b0;
        req = 4'b1111;
        #1;
        checks++; if (gnt !== '0) begin errs++; $display("FAIL rstmid_gnt: got %b want 0", gnt); end
        checks++; if (fifo_din !== '0) begin errs++; $display("FAIL rstmid_din: got %h want 0", fifo_din); end
        checks++; if (level !== '0) begin errs++; $display("FAIL rstmid_level: got %0d want 0", level); end
        checks++; if (wr_busy !== 1'b0) begin errs++; $display("FAIL rstmid_wr_busy: got %b want 0", wr_busy); end
        checks++; if (rd_busy !== 1'b0) begin errs++; $display("FAIL rstmid_rd_busy: got %b want 0", rd_busy); end
        checks++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL rstmid_rd_valid: got %b want 0", rd_valid); end
        tick();
        checks++; if (gnt !== 4'b0001) begin errs++; $display("FAIL rstmid_first_gnt: got %b want 0001", gnt); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_thresh_drain();
        test_round_robin();
        test_full_stall();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no summary want summary");
        $fatal(1);
    end

endmodule

// File: doc/npu_fifo_burst_arbiter.md
Name: npu_fifo_burst_arbiter

Overview:
Controller in front of the NPU's large 16-bit circular-buffer FIFO. Shares the single FIFO write port among NREQ producers using burst round-robin arbitration. Schedules drain bursts on the read port when occupancy crosses a threshold or a flush is requested. Tracks FIFO occupancy internally and reports it.

Parameters:
NREQ, 4, number of write requesters (2..8)
DW, 16, data width
DEPTH, 32, FIFO capacity in words; must match the attached FIFO
BURST_LEN, 4, max words per write grant before re-arbitration
DRAIN_THRESH, 8, level at or above which a drain burst starts
DRAIN_LEN, 8, max reads per drain burst
LW, 6, level counter width, i.e. clog2(DEPTH+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req  in  NREQ  per-requester write request; data valid while high
req_data  in  NREQ*DW  packed data; requester i in bits [i*DW +: DW]
gnt  out  NREQ  one-hot; bit i high = requester i's word accepted this cycle
fifo_din  out  DW  to FIFO din
fifo_wr_en  out  1  to FIFO wr_en
fifo_full  in  1  from FIFO
fifo_empty  in  1  from FIFO
fifo_rd_en  out  1  to FIFO rd_en
cons_ready  in  1  consumer can take a word this cycle
flush  in  1  pulse; drain everything regardless of threshold
rd_valid  out  1  registered; FIFO dout is valid (1 cycle after fifo_rd_en)
level  out  LW  registered occupancy
wr_busy  out  1  write FSM in W_BURST
rd_busy  out  1  read FSM in R_DRAIN

Behaviour:
- Reset: gnt=0, fifo_wr_en=0, fifo_din=0, fifo_rd_en=0, rd_valid=0, level=0, wr_busy=0, rd_busy=0. Both FSMs go to idle, rr pointer=0, burst and drain counters=0, flush_pend=0. A reset mid-burst aborts the burst immediately with no further gnt.
- Write FSM W_IDLE / W_BURST:
  - W_IDLE: if any req, owner = first set bit searching from rr pointer upward with wrap. Go to W_BURST, burst count=0. No writes in W_IDLE, so each grant costs 1 arbitration cycle.
  - W_BURST: gnt = onehot(owner) & req[owner] & !fifo_full. This is combinational, zero latency. fifo_wr_en = |gnt. fifo_din = req_data slice of owner. fifo_din holds its last value when there is no write.
  - Burst count increments on each accepted word.
  - Return to W_IDLE when BURST_LEN words have been accepted, or when req[owner] is low. A full FIFO stalls the burst; it does not end it.
  - On return, rr pointer = owner+1 mod NREQ.
- Read FSM R_IDLE / R_DRAIN:
  - R_IDLE to R_DRAIN when level >= DRAIN_THRESH or flush_pend. Drain count=0.
  - R_DRAIN: fifo_rd_en = cons_ready & !fifo_empty. This is combinational. Drain count increments per read.
  - Exit to R_IDLE after DRAIN_LEN reads, or when fifo_empty is seen with no read. In flush mode the DRAIN_LEN limit is ignored until empty.
  - rd_valid <= fifo_rd_en (registered).
- flush: sets flush_pend, which clears when the flush drain exits on empty. Flush while already in R_DRAIN converts that drain to flush mode.
- level: +1 on write only, -1 on read only, unchanged on simultaneous write and read. It never wraps. Writes are blocked at fifo_full, reads at fifo_empty.
- Simultaneous W_BURST write and R_DRAIN read in the same cycle is permitted.

Optional Feature:
NPU_ARB_HIPRI_EN
- Defined: requester 0 is high priority. In W_IDLE, req[0] always wins over the rr pointer. If req[0] rises during another owner's burst, that burst ends after its current cycle and requester 0 is granted after the arbitration cycle. rr pointer is not updated by requester-0 grants.
- Undefined: pure round-robin as above; req[0] gets no special treatment.

Test Plan:
- Single requester: req[2] held high with data 0x0100..0x0107, other req low. Expect gnt[2] in bursts of 4 words separated by 1 idle cycle. FIFO receives 0x0100..0x0107 in order. level reaches 8, then a drain starts.
- Round-robin: all 4 req held high. Expect grant order 0,1,2,3,0 with 4 words each. Check gnt is one-hot every cycle, and the rr pointer after owner 3 wraps to 0.
- Full stall: fill to level=32 with cons_ready=0. Expect fifo_full, gnt=0 and fifo_wr_en=0 while req stays high, and no level overflow. Raise cons_ready: reads resume and writes restart the next cycle after space frees.
- Threshold drain: write 8 words, cons_ready=1. Expect rd_busy and 8 fifo_rd_en pulses, rd_valid lagging by 1 cycle, level back to 0.
- Flush: write 3 words (below threshold), pulse flush. Expect 3 reads, exit on empty, flush_pend cleared.
- Reset mid-operation: assert rst during W_BURST with 2 of 4 words written. Next cycle all outputs are 0, level=0, and the first post-reset grant goes to requester 0.
